// File: rtl/peri_arbiter_if.sv
// Signal bundle between the NanoCore peripheral requesters, the shared peripheral port and peri_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface peri_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    i_req_rden;
  logic [NUM_REQ-1:0]    i_req_wren;
  logic [NUM_REQ*32-1:0] i_req_addr;
  logic [NUM_REQ*32-1:0] i_req_wdata;
  logic [NUM_REQ*4-1:0]  i_req_wstrb;
  logic [NUM_REQ-1:0]    o_req_gnt;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [31:0]           o_req_rdata;
  logic                  o_req_err;
  logic                  o_peri_rden;
  logic                  o_peri_wren;
  logic [31:0]           o_peri_addr;
  logic [31:0]           o_peri_wdata;
  logic [3:0]            o_peri_wstrb;
  logic [31:0]           i_peri_rdata;
  logic                  i_peri_ready;
  logic                  i_peri_gnt;
  logic                  o_busy;
  logic [15:0]           o_timeout_cnt;

  modport master (
    input  i_req_rden, i_req_wren, i_req_addr, i_req_wdata, i_req_wstrb,
    input  i_peri_rdata, i_peri_ready, i_peri_gnt,
    output o_req_gnt, o_req_ready, o_req_rdata, o_req_err,
    output o_peri_rden, o_peri_wren, o_peri_addr, o_peri_wdata, o_peri_wstrb,
    output o_busy, o_timeout_cnt
  );

  modport slave (
    output i_req_rden, i_req_wren, i_req_addr, i_req_wdata, i_req_wstrb,
    output i_peri_rdata, i_peri_ready, i_peri_gnt,
    input  o_req_gnt, o_req_ready, o_req_rdata, o_req_err,
    input  o_peri_rden, o_peri_wren, o_peri_addr, o_peri_wdata, o_peri_wstrb,
    input  o_busy, o_timeout_cnt
  );
endinterface

// File: rtl/peri_arbiter.sv
// Round-robin arbiter sharing one peripheral port among NUM_REQ cores, one transaction in flight,
// with a WAIT-state response timeout so a dead peripheral cannot hang a core.
module peri_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input logic          i_clk,
  input logic          i_rst,
  peri_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PTR_W:0]   NREQ_W    = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rdy_q, rdy_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               rden_q, rden_d;
  logic               wren_q, wren_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [15:0]        tocnt_q, tocnt_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] active;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic               done;
  logic               done_err;
  logic [31:0]        done_data;

  assign active = bus.i_req_rden | bus.i_req_wren;

  // First active requester scanning upward from ptr_q, wrapping at NUM_REQ.
  always_comb begin
    logic [PTR_W:0] sum;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && active[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    rdy_d     = '0;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    rden_d    = rden_q;
    wren_d    = wren_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    tocnt_d   = tocnt_q;
    done      = 1'b0;
    done_err  = 1'b0;
    done_data = bus.i_peri_rdata;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ISSUE;
          win_d       = pick;
          gnt_d[pick] = 1'b1;
          wren_d      = bus.i_req_wren[pick];
          rden_d      = !bus.i_req_wren[pick];
          addr_d      = bus.i_req_addr[int'(pick)*32 +: 32];
          wdata_d     = bus.i_req_wdata[int'(pick)*32 +: 32];
          wstrb_d     = bus.i_req_wstrb[int'(pick)*4 +: 4];
        end
      end
      ISSUE: begin
        if (bus.i_peri_gnt) begin
          rden_d = 1'b0;
          wren_d = 1'b0;
          if (bus.i_peri_ready) begin
            done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        // A response landing on the timeout cycle still counts as a normal completion.
        if (bus.i_peri_ready) begin
          done = 1'b1;
        end else if (TIMEOUT != 0 && cnt_q == TIMEOUT_C) begin
          done      = 1'b1;
          done_err  = 1'b1;
          done_data = 32'hDEAD_BEEF;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d      = IDLE;
      rdy_d[win_q] = 1'b1;
      rdata_d      = done_data;
      err_d        = done_err;
      ptr_d        = (win_q == LAST_REQ) ? '0 : win_q + PTR_W'(1);
      if (done_err && tocnt_q != '1) tocnt_d = tocnt_q + 16'd1;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rdy_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      tocnt_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rden_q  <= rden_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      tocnt_q <= tocnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_req_gnt     = gnt_q;
  assign bus.o_req_ready   = rdy_q;
  assign bus.o_req_rdata   = rdata_q;
  assign bus.o_req_err     = err_q;
  assign bus.o_peri_rden   = rden_q;
  assign bus.o_peri_wren   = wren_q;
  assign bus.o_peri_addr   = addr_q;
  assign bus.o_peri_wdata  = wdata_q;
  assign bus.o_peri_wstrb  = wstrb_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_timeout_cnt = tocnt_q;
endmodule

// File: tb/tb_peri_arbiter.sv
// Bench for peri_arbiter: transaction-level reference model checked every cycle, plus directed
// scenarios with hand-computed grant/completion cycles and data.
module tb_peri_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;

  peri_arbiter_if #(.NUM_REQ(N)) bus ();

  peri_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who owns the port, whether the request is still on the bus, cycles waited.
  int          m_owner;
  bit          m_onbus;
  bit          m_wr;
  int          m_waited;
  int          m_rr;
  int          m_tocnt;
  int          m_k;
  logic [3:0]  m_gnt, m_rdy, m_wstrb;
  logic [31:0] m_rdata, m_addr, m_wdata;
  bit          m_err;

  task automatic m_finish(input logic [31:0] d, input bit e);
    m_rdy[m_owner] = 1'b1;
    m_rdata = d;
    m_err   = e;
    m_rr    = (m_owner + 1) % N;
    m_owner = -1;
    if (e && m_tocnt < 65535) m_tocnt++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_onbus = 0; m_wr = 0; m_waited = 0; m_rr = 0; m_tocnt = 0;
      m_gnt = '0; m_rdy = '0; m_rdata = '0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_wstrb = '0;
    end else begin
      m_gnt = '0; m_rdy = '0; m_err = 0;
      if (m_owner < 0) begin
        for (int i = 0; i < N; i++) begin
          m_k = (m_rr + i) % N;
          if (m_owner < 0 && (bus.i_req_rden[m_k] || bus.i_req_wren[m_k])) begin
            m_owner    = m_k;
            m_onbus    = 1;
            m_wr       = bus.i_req_wren[m_k];
            m_gnt[m_k] = 1'b1;
            m_addr     = bus.i_req_addr[m_k*32 +: 32];
            m_wdata    = bus.i_req_wdata[m_k*32 +: 32];
            m_wstrb    = bus.i_req_wstrb[m_k*4 +: 4];
          end
        end
      end else if (m_onbus) begin
        if (bus.i_peri_gnt) begin
          m_onbus = 0;
          if (bus.i_peri_ready) m_finish(bus.i_peri_rdata, 0);
          else m_waited = 0;
        end
      end else begin
        if (bus.i_peri_ready) m_finish(bus.i_peri_rdata, 0);
        else if (m_waited == TO) m_finish(32'hDEAD_BEEF, 1);
        else m_waited++;
      end
    end
  end

  // Event log and per-cycle comparison against the model.
  int          gnt_idx_q[$];
  int          gnt_cyc_q[$];
  int          rdy_idx_q[$];
  int          rdy_cyc_q[$];
  logic [31:0] rdy_data_q[$];
  bit          rdy_err_q[$];
  int          rden_n = 0;
  int          wren_n = 0;
  logic [31:0] strobe_addr;
  logic [3:0]  strobe_wstrb;

  always @(negedge clk) begin
    if (!rst) begin
      check("gnt",    64'(bus.o_req_gnt),     64'(m_gnt));
      check("ready",  64'(bus.o_req_ready),   64'(m_rdy));
      check("rdata",  64'(bus.o_req_rdata),   64'(m_rdata));
      check("err",    64'(bus.o_req_err),     64'(m_err));
      check("rden",   64'(bus.o_peri_rden),   64'(m_onbus && !m_wr));
      check("wren",   64'(bus.o_peri_wren),   64'(m_onbus && m_wr));
      check("addr",   64'(bus.o_peri_addr),   64'(m_addr));
      check("wdata",  64'(bus.o_peri_wdata),  64'(m_wdata));
      check("wstrb",  64'(bus.o_peri_wstrb),  64'(m_wstrb));
      check("busy",   64'(bus.o_busy),        64'(m_owner >= 0));
      check("tocnt",  64'(bus.o_timeout_cnt), 64'(m_tocnt));
      for (int k = 0; k < N; k++) begin
        if (bus.o_req_gnt[k]) begin gnt_idx_q.push_back(k); gnt_cyc_q.push_back(cyc); end
        if (bus.o_req_ready[k]) begin
          rdy_idx_q.push_back(k); rdy_cyc_q.push_back(cyc);
          rdy_data_q.push_back(bus.o_req_rdata); rdy_err_q.push_back(bus.o_req_err);
        end
      end
      if (bus.o_peri_rden) rden_n++;
      if (bus.o_peri_wren) wren_n++;
      if (bus.o_peri_rden || bus.o_peri_wren) begin
        strobe_addr  = bus.o_peri_addr;
        strobe_wstrb = bus.o_peri_wstrb;
      end
    end
  end

  // Peripheral responder: stall gnt for gnt_wait cycles, then raise ready lat cycles after acceptance
  // (0 = same cycle as gnt, negative = never).
  int          gnt_wait = 0;
  int          lat = 1;
  int          stall_n = 0;
  int          pend = 0;
  int          acc_n = 0;
  int          acc_cyc = 0;
  logic [31:0] rsp_data = '0;

  task automatic tick();
    @(negedge clk);
    #2;
    for (int k = 0; k < N; k++)
      if (bus.o_req_gnt[k]) begin bus.i_req_rden[k] = 1'b0; bus.i_req_wren[k] = 1'b0; end
    bus.i_peri_gnt   = 1'b0;
    bus.i_peri_ready = 1'b0;
    bus.i_peri_rdata = 32'h0BAD_0BAD;
    if (bus.o_peri_rden || bus.o_peri_wren) begin
      if (stall_n < gnt_wait) stall_n++;
      else begin
        bus.i_peri_gnt = 1'b1;
        acc_n++;
        acc_cyc = cyc;
        stall_n = 0;
        if (lat == 0) begin bus.i_peri_ready = 1'b1; bus.i_peri_rdata = rsp_data; end
        else pend = lat;
      end
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin bus.i_peri_ready = 1'b1; bus.i_peri_rdata = rsp_data; end
    end
  endtask

  task automatic req(input int k, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    bus.i_req_rden[k] = rd;
    bus.i_req_wren[k] = wr;
    bus.i_req_addr[k*32 +: 32]  = a;
    bus.i_req_wdata[k*32 +: 32] = d;
    bus.i_req_wstrb[k*4 +: 4]   = s;
  endtask

  task automatic run_until(input int target, input int budget);
    int b;
    b = budget;
    while (rdy_idx_q.size() < target && b > 0) begin
      tick();
      b--;
    end
    check("wait_completions", 64'(rdy_idx_q.size()), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, g0, r0, rd0, wr0, a0;
    bus.i_req_rden = '0; bus.i_req_wren = '0;
    bus.i_req_addr = '0; bus.i_req_wdata = '0; bus.i_req_wstrb = '0;
    bus.i_peri_rdata = '0; bus.i_peri_ready = 1'b0; bus.i_peri_gnt = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy",  64'(bus.o_busy), 64'(0));
    check("rst_gnt",   64'(bus.o_req_gnt), 64'(0));
    check("rst_rdata", 64'(bus.o_req_rdata), 64'(0));
    check("rst_tocnt", 64'(bus.o_timeout_cnt), 64'(0));
    check("rst_strb",  64'({bus.o_peri_rden, bus.o_peri_wren}), 64'(0));
    check("rst_addr",  64'(bus.o_peri_addr), 64'(0));

    // Round robin from ptr 0: all four at once, then PE0 and PE3.
    gnt_wait = 0; lat = 1; rsp_data = 32'h0000_1234;
    g0 = gnt_idx_q.size(); r0 = rdy_idx_q.size();
    for (int k = 0; k < N; k++) req(k, 1, 0, 32'h2000_0000 + 32'(k * 4), '0, 4'hF);
    run_until(r0 + 4, 60);
    for (int i = 0; i < 4; i++)
      if (gnt_idx_q.size() > g0 + i) check("rr_order", 64'(gnt_idx_q[g0 + i]), 64'(i));
    tick();
    req(0, 1, 0, 32'h2000_0100, '0, 4'hF);
    req(3, 1, 0, 32'h2000_0300, '0, 4'hF);
    run_until(r0 + 6, 30);
    if (gnt_idx_q.size() > g0 + 5) begin
      check("rr_second_first", 64'(gnt_idx_q[g0 + 4]), 64'(0));
      check("rr_second_next",  64'(gnt_idx_q[g0 + 5]), 64'(3));
    end

    // Single read by PE2.
    tick();
    rsp_data = 32'hA5A5_0001;
    g0 = gnt_idx_q.size(); r0 = rdy_idx_q.size(); rd0 = rden_n;
    req(2, 1, 0, 32'h1000_0004, '0, 4'hF);
    t = cyc;
    run_until(r0 + 1, 20);
    if (rdy_idx_q.size() > r0 && gnt_idx_q.size() > g0) begin
      check("rd_gnt_idx",   64'(gnt_idx_q[g0]), 64'(2));
      check("rd_gnt_cyc",   64'(gnt_cyc_q[g0]), 64'(t + 1));
      check("rd_rdy_idx",   64'(rdy_idx_q[r0]), 64'(2));
      check("rd_rdy_cyc",   64'(rdy_cyc_q[r0]), 64'(t + 3));
      check("rd_rdy_data",  64'(rdy_data_q[r0]), 64'h0000_0000_A5A5_0001);
    end
    check("rd_strobe_n",  64'(rden_n - rd0), 64'(1));
    check("rd_addr",      64'(strobe_addr), 64'h0000_0000_1000_0004);

    // Downstream stall: gnt withheld 5 cycles on a write from PE1.
    tick();
    gnt_wait = 5; lat = 1; rsp_data = 32'h0000_0077;
    r0 = rdy_idx_q.size(); wr0 = wren_n; a0 = acc_n;
    req(1, 0, 1, 32'h3000_0008, 32'hCAFE_0001, 4'hF);
    t = cyc;
    run_until(r0 + 1, 30);
    check("st_wren_cycles", 64'(wren_n - wr0), 64'(6));
    check("st_accepts",     64'(acc_n - a0), 64'(1));
    check("st_acc_cyc",     64'(acc_cyc), 64'(t + 6));
    if (rdy_idx_q.size() > r0) check("st_rdy_cyc", 64'(rdy_cyc_q[r0]), 64'(t + 8));

    // Timeout: no response, then response exactly on the limit cycle.
    tick();
    gnt_wait = 0; lat = -1;
    r0 = rdy_idx_q.size();
    req(0, 1, 0, 32'h3000_0010, '0, 4'hF);
    t = cyc;
    run_until(r0 + 1, 30);
    if (rdy_idx_q.size() > r0) begin
      check("to_rdy_cyc",  64'(rdy_cyc_q[r0]), 64'(t + 11));
      check("to_rdy_data", 64'(rdy_data_q[r0]), 64'h0000_0000_DEAD_BEEF);
      check("to_err",      64'(rdy_err_q[r0]), 64'(1));
    end
    check("to_cnt", 64'(bus.o_timeout_cnt), 64'(1));
    tick();
    lat = 9; rsp_data = 32'h1111_2222;
    r0 = rdy_idx_q.size();
    req(1, 1, 0, 32'h3000_0014, '0, 4'hF);
    t = cyc;
    run_until(r0 + 1, 30);
    if (rdy_idx_q.size() > r0) begin
      check("lim_rdy_cyc",  64'(rdy_cyc_q[r0]), 64'(t + 11));
      check("lim_rdy_data", 64'(rdy_data_q[r0]), 64'h0000_0000_1111_2222);
      check("lim_err",      64'(rdy_err_q[r0]), 64'(0));
    end
    check("lim_cnt", 64'(bus.o_timeout_cnt), 64'(1));

    // rden and wren together from PE2: write wins; best-case latency.
    tick();
    lat = 0; rsp_data = 32'h0000_0099;
    r0 = rdy_idx_q.size(); rd0 = rden_n; wr0 = wren_n;
    req(2, 1, 1, 32'h4000_000C, 32'h5555_AAAA, 4'b0011);
    t = cyc;
    run_until(r0 + 1, 20);
    check("both_rden",  64'(rden_n - rd0), 64'(0));
    check("both_wren",  64'(wren_n - wr0), 64'(1));
    check("both_wstrb", 64'(strobe_wstrb), 64'(4'b0011));
    if (rdy_idx_q.size() > r0) check("both_rdy_cyc", 64'(rdy_cyc_q[r0]), 64'(t + 2));

    // Reset while PE1 waits; afterwards ptr is back to 0 so PE1 beats PE3.
    tick();
    lat = -1;
    req(1, 1, 0, 32'h5000_0010, '0, 4'hF);
    repeat (3) tick();
    check("rw_busy_pre", 64'(bus.o_busy), 64'(1));
    r0 = rdy_idx_q.size();
    rst = 1'b1;
    #1;
    check("rw_busy",  64'(bus.o_busy), 64'(0));
    check("rw_addr",  64'(bus.o_peri_addr), 64'(0));
    check("rw_rdata", 64'(bus.o_req_rdata), 64'(0));
    check("rw_strb",  64'({bus.o_peri_rden, bus.o_peri_wren, bus.o_req_ready, bus.o_req_gnt}), 64'(0));
    check("rw_tocnt", 64'(bus.o_timeout_cnt), 64'(0));
    bus.i_req_rden = '0; bus.i_req_wren = '0;
    pend = 0; stall_n = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rw_no_ready", 64'(rdy_idx_q.size()), 64'(r0));
    lat = 1; rsp_data = 32'h0000_0042;
    g0 = gnt_idx_q.size();
    req(3, 1, 0, 32'h6000_0030, '0, 4'hF);
    req(1, 1, 0, 32'h6000_0010, '0, 4'hF);
    run_until(r0 + 2, 30);
    if (gnt_idx_q.size() > g0 + 1) begin
      check("rw_first_gnt",  64'(gnt_idx_q[g0]), 64'(1));
      check("rw_second_gnt", 64'(gnt_idx_q[g0 + 1]), 64'(3));
    end
    if (rdy_idx_q.size() > r0) check("rw_data", 64'(rdy_data_q[r0]), 64'h0000_0000_0000_0042);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
